conv_window_buffer: RTL and testbench



---
 rtl/conv_pkg.sv | 23 ++
 rtl/line_fifo.sv | 24 ++
 rtl/conv_window_buffer.sv | 130 +++++++++++++
 tb/tb_conv_window_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and window tap indices for the 3x3 window generator.
package conv_pkg;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned K      = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } win_state_t;

    // Row/column tap positions inside the window: 0 is oldest, K-1 is newest.
    localparam int unsigned TAP_OLD = 0;
    localparam int unsigned TAP_MID = 1;
    localparam int unsigned TAP_NEW = K - 1;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Single-row circular buffer with external address; a same-cycle read returns the old entry.
module line_fifo #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned WIDTH = 6,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator: raster pixels in, one packed window per
// qualifying pixel out, with per-frame row/column counters and a last-window pulse.
module conv_window_buffer #(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned K      = conv_pkg::K,
    localparam int unsigned CW    = $clog2(IMG_W),
    localparam int unsigned RW    = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_dv,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic                  win_dv,
    output logic                  frame_done,
    output logic [RW-1:0]         row_cnt,
    output logic [CW-1:0]         col_cnt
);

    import conv_pkg::*;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          win_dv_q;
    logic          frame_done_q;
    win_state_t    state_q, state_d;

    // Packed so that [r][c] lands at bit offset (r*K + c)*DATA_W.
    logic [K-1:0][K-1:0][DATA_W-1:0] win_q;

    logic [DATA_W-1:0] lb0_out;
    logic [DATA_W-1:0] lb1_out;

    logic accept;
    logic col_last;
    logic frame_last;
    logic win_ok;

    assign accept     = in_dv & ~clear;
    assign col_last   = (col_q == COL_LAST);
    assign frame_last = col_last & (row_q == ROW_LAST);
    assign win_ok     = (row_q >= ROW_MIN) & (col_q >= COL_MIN);

    // lb0 is fed from lb1's old entry, so it always lags one row behind lb1.
    line_fifo #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (lb1_out),
        .rd_data (lb0_out)
    );

    line_fifo #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (in_data),
        .rd_data (lb1_out)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = FILL;
            FILL: if (accept && row_q == ROW_MIN && col_q == '0) state_d = RUN;
            RUN:  if (accept && frame_last) state_d = DONE;
            DONE: state_d = accept ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_dv_q     <= 1'b0;
            frame_done_q <= 1'b0;
            state_q      <= IDLE;
        end else if (clear) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_dv_q     <= 1'b0;
            frame_done_q <= 1'b0;
            state_q      <= IDLE;
        end else begin
            win_dv_q     <= accept & win_ok;
            frame_done_q <= accept & frame_last;
            state_q      <= state_d;
            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                end
                win_q[TAP_OLD][TAP_NEW] <= lb0_out;
                win_q[TAP_MID][TAP_NEW] <= lb1_out;
                win_q[TAP_NEW][TAP_NEW] <= in_data;
            end
        end
    end

    assign win_data   = win_q;
    assign win_dv     = win_dv_q;
    assign frame_done = frame_done_q;
    assign row_cnt    = row_q;
    assign col_cnt    = col_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer on a 5x4 image with a window scoreboard.
module tb_conv_window_buffer;

    localparam int DW   = 6;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int WINW = 9 * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [DW-1:0]   in_data;
    logic            in_dv;
    logic [WINW-1:0] win_data;
    logic            win_dv;
    logic            frame_done;
    logic [1:0]      row_cnt;
    logic [2:0]      col_cnt;

    int errors   = 0;
    int checks   = 0;
    int win_seen = 0;
    int cycle    = 0;
    int fd_last  = -1;
    int fd_prev  = -1;

    logic [WINW-1:0] exp_win_q[$];
    logic            exp_fd_q[$];

    conv_window_buffer #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .K      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_dv      (in_dv),
        .win_data   (win_data),
        .win_dv     (win_dv),
        .frame_done (frame_done),
        .row_cnt    (row_cnt),
        .col_cnt    (col_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Scoreboard consumer: every window the DUT emits must match the next expected one.
    always @(negedge clk) begin
        logic [WINW-1:0] ew;
        logic            ef;
        if (win_dv === 1'b1) begin
            win_seen++;
            checks++;
            if (exp_win_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_win: got win_data=%h with empty scoreboard", win_data);
            end else begin
                ew = exp_win_q.pop_front();
                ef = exp_fd_q.pop_front();
                if (win_data !== ew || frame_done !== ef) begin
                    errors++;
                    $display("FAIL window: got %h fd=%b, expected %h fd=%b",
                             win_data, frame_done, ew, ef);
                end
            end
            if (frame_done === 1'b1) begin
                fd_prev = fd_last;
                fd_last = cycle;
            end
        end else if (frame_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: got %b, expected 0 without win_dv", frame_done);
        end
    end

    function automatic logic [WINW-1:0] build_win(input int base, input int p);
        logic [WINW-1:0] w;
        int r, c, idx;
        r = p / W;
        c = p % W;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                idx = (r - 2 + rr) * W + (c - 2 + cc);
                w[(rr*3+cc)*DW +: DW] = DW'((base + idx) % 64);
            end
        end
        return w;
    endfunction

    task automatic idle_cycle();
        in_dv = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (win_dv !== 1'b0) begin
            errors++;
            $display("FAIL gap_win_dv: got %b, expected 0", win_dv);
        end
    endtask

    task automatic push_pixel(input int base, input int p);
        bit qual;
        qual    = (p / W >= 2) && (p % W >= 2);
        in_data = DW'((base + p) % 64);
        in_dv   = 1'b1;
        if (qual) begin
            exp_win_q.push_back(build_win(base, p));
            exp_fd_q.push_back(p == W * H - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (win_dv !== qual) begin
            errors++;
            $display("FAIL win_dv_latency: pixel %0d got %b, expected %b", p, win_dv, qual);
        end
        checks++;
        if (col_cnt !== 3'((p + 1) % W) || row_cnt !== 2'(((p + 1) / W) % H)) begin
            errors++;
            $display("FAIL counters: pixel %0d got row=%0d col=%0d, expected row=%0d col=%0d",
                     p, row_cnt, col_cnt, ((p + 1) / W) % H, (p + 1) % W);
        end
    endtask

    task automatic send_frame(input int base, input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) idle_cycle();
            end
            push_pixel(base, p);
        end
    endtask

    task automatic check_count(input string name, input int start, input int want);
        checks++;
        if (win_seen - start !== want) begin
            errors++;
            $display("FAIL %s_count: got %0d windows, expected %0d", name, win_seen - start, want);
        end
        checks++;
        if (exp_win_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending windows, expected 0", name, exp_win_q.size());
        end
        exp_win_q.delete();
        exp_fd_q.delete();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clear   = 1'b0;
        in_dv   = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (win_data !== '0 || win_dv !== 1'b0 || frame_done !== 1'b0 ||
            row_cnt !== 2'd0 || col_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got win=%h dv=%b fd=%b row=%0d col=%0d, expected all 0",
                     win_data, win_dv, frame_done, row_cnt, col_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int s0 = win_seen;
        send_frame(0, 1'b0, W * H);
        repeat (2) idle_cycle();
        check_count("stream", s0, 6);
    endtask

    task automatic test_gaps();
        int s0 = win_seen;
        send_frame(20, 1'b1, W * H);
        repeat (2) idle_cycle();
        check_count("gaps", s0, 6);
    endtask

    task automatic test_clear();
        int s0;
        send_frame(40, 1'b0, 9);
        in_dv = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (row_cnt !== 2'd0 || col_cnt !== 3'd0 || win_data !== '0 || win_dv !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got row=%0d col=%0d win=%h dv=%b, expected all 0",
                     row_cnt, col_cnt, win_data, win_dv);
        end
        s0 = win_seen;
        send_frame(0, 1'b0, W * H);
        repeat (2) idle_cycle();
        check_count("clear", s0, 6);
    endtask

    task automatic test_back_to_back();
        int s0 = win_seen;
        send_frame(10, 1'b0, W * H);
        send_frame(30, 1'b0, W * H);
        repeat (2) idle_cycle();
        check_count("b2b", s0, 12);
        checks++;
        if (fd_last - fd_prev !== W * H) begin
            errors++;
            $display("FAIL b2b_fd_spacing: got %0d cycles, expected %0d", fd_last - fd_prev, W * H);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        send_frame(0, 1'b0, 15);
        in_dv = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (win_data !== '0 || win_dv !== 1'b0 || frame_done !== 1'b0 ||
            row_cnt !== 2'd0 || col_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got win=%h dv=%b fd=%b row=%0d col=%0d, expected all 0",
                     win_data, win_dv, frame_done, row_cnt, col_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        s0 = win_seen;
        check_count("reset_mid_pre", s0, 0);
        send_frame(5, 1'b0, W * H);
        repeat (2) idle_cycle();
        check_count("reset_mid", s0, 6);
    endtask

    task automatic test_clear_with_dv();
        clear   = 1'b1;
        in_dv   = 1'b1;
        in_data = 6'd33;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_dv = 1'b0;
        checks++;
        if (col_cnt !== 3'd0 || win_dv !== 1'b0 || win_data !== '0) begin
            errors++;
            $display("FAIL clear_dv_drop: got col=%0d dv=%b win=%h, expected 0/0/0",
                     col_cnt, win_dv, win_data);
        end
        in_data = 6'd21;
        in_dv   = 1'b1;
        @(posedge clk);
        #1;
        in_dv = 1'b0;
        checks++;
        if (col_cnt !== 3'd1 || win_data[8*DW +: DW] !== 6'd21 ||
            win_data[7*DW +: DW] !== 6'd0) begin
            errors++;
            $display("FAIL clear_dv_next: got col=%0d new=%0d prev=%0d, expected 1/21/0",
                     col_cnt, win_data[8*DW +: DW], win_data[7*DW +: DW]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_clear_with_dv();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
